ic_fill_ctrl: RTL and testbench

Instruction-cache miss/refill controller. It sits between the icache lookup stage and the DRAM arbiter's initiator-0 port. It accepts line misses and issues 16-byte line reads tagged with up to 4 transaction IDs. It merges duplicate misses to in-flight lines, matches returned data to its XID slot, and presents a registered fill (address and data) to the cache array.

---
 rtl/ic_pkg.sv | 27 ++
 rtl/ic_xid_alloc.sv | 33 +++
 rtl/ic_fill_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ic_fill_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// ---------------------------------------------------------------------------
// ic_pkg: shared types and constants for the instruction-cache refill
// controller (ic_fill_ctrl) and its XID allocator (ic_xid_alloc).
//   line_addr_t  : 16-byte line address, bits [26:4] of the byte address
//   xid_t        : transaction ID of an outstanding line read
//   cnt_t        : busy-slot count, 0..N_XID
//   line_data_t  : one 128-bit cache line
//   fill_state_e : controller mode, IDLE (normal) or DRAIN (flushing)
// ---------------------------------------------------------------------------
package ic_pkg;

  localparam int LG_XID  = 2;
  localparam int N_XID   = 1 << LG_XID;
  localparam int ADDR_HI = 26;
  localparam int ADDR_LO = 4;

  typedef logic [ADDR_HI:ADDR_LO] line_addr_t;
  typedef logic [LG_XID-1:0]      xid_t;
  typedef logic [LG_XID:0]        cnt_t;
  typedef logic [127:0]           line_data_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } fill_state_e;

endpackage

// File: rtl/ic_xid_alloc.sv
// ---------------------------------------------------------------------------
// ic_xid_alloc: XID slot bookkeeping helper. Purely combinational.
//   busy_i      : one busy bit per XID slot
//   any_free_o  : at least one slot is idle
//   free_idx_o  : lowest-numbered idle slot (0 when none is free)
//   count_o     : number of busy slots
// ---------------------------------------------------------------------------
module ic_xid_alloc
  import ic_pkg::*;
(
  input  logic [N_XID-1:0] busy_i,
  output logic             any_free_o,
  output xid_t             free_idx_o,
  output cnt_t             count_o
);

  always_comb begin
    any_free_o = 1'b0;
    free_idx_o = '0;
    count_o    = '0;
    // Walk from the top down so the last hit is the lowest free index.
    for (int i = N_XID - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        any_free_o = 1'b1;
        free_idx_o = xid_t'(i);
      end
    end
    for (int i = 0; i < N_XID; i++) begin
      count_o = count_o + cnt_t'(busy_i[i]);
    end
  end

endmodule

// File: rtl/ic_fill_ctrl.sv
// ---------------------------------------------------------------------------
// ic_fill_ctrl: instruction-cache miss/refill controller.
// Accepts line misses from the lookup stage, issues 16-byte line reads to
// the DRAM arbiter tagged with one of N_XID transaction IDs, merges misses
// to lines already in flight, and turns each returned line into a one-cycle
// registered fill for the cache array.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   miss_valid/miss_addr      miss request from lookup
//   miss_ready                miss accepted when miss_valid & miss_ready
//   flush / flush_done        drain request pulse / drain-complete pulse
//   ic_mem_addr/xid/re        read command to the arbiter
//   mem_ic_ready              arbiter accepts when ic_mem_re & mem_ic_ready
//   mem_ic_valid/xid/data     returned line for a previously issued XID
//   fill_valid/addr/data      registered fill to the cache array
//   busy_cnt                  number of busy XID slots
//   err_spurious              sticky: a response arrived for an idle XID
//   state_dbg                 current controller mode, for observation
//
// Handshakes: both miss and command channels are strict valid/ready. A
// transfer happens on a rising edge where valid and ready are both high;
// the initiator holds valid and its payload stable until that edge, and
// ready never depends on valid.
// ---------------------------------------------------------------------------
module ic_fill_ctrl
  import ic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_valid,
  input  line_addr_t  miss_addr,
  output logic        miss_ready,
  input  logic        flush,
  output logic        flush_done,
  output line_addr_t  ic_mem_addr,
  output xid_t        ic_mem_xid,
  output logic        ic_mem_re,
  input  logic        mem_ic_ready,
  input  logic        mem_ic_valid,
  input  xid_t        mem_xxx_xid,
  input  line_data_t  mem_xxx_data,
  output logic        fill_valid,
  output line_addr_t  fill_addr,
  output line_data_t  fill_data,
  output cnt_t        busy_cnt,
  output logic        err_spurious,
  output fill_state_e state_dbg
);

  // Slot table
  logic [N_XID-1:0] busy_q, busy_d;
  line_addr_t       slot_addr_q [N_XID];
  line_addr_t       slot_addr_d [N_XID];

  // Issue register
  line_addr_t iss_addr_q, iss_addr_d;
  xid_t       iss_xid_q, iss_xid_d;
  logic       pend_q, pend_d;

  // Fill register and status
  logic       fill_valid_q, fill_valid_d;
  line_addr_t fill_addr_q, fill_addr_d;
  line_data_t fill_data_q, fill_data_d;
  logic       err_q, err_d;
  logic       flush_done_q, flush_done_d;

  fill_state_e state_q, state_d;

  logic any_free;
  xid_t free_idx;
  cnt_t busy_count;
  logic merge_hit;
  logic miss_acc;
  logic alloc;
  logic drained;

  // Allocation looks only at the registered busy vector, so a slot being
  // freed this cycle cannot be handed out again until the next cycle.
  ic_xid_alloc u_alloc (
    .busy_i     (busy_q),
    .any_free_o (any_free),
    .free_idx_o (free_idx),
    .count_o    (busy_count)
  );

  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < N_XID; i++) begin
      if (busy_q[i] && (slot_addr_q[i] == miss_addr)) begin
        merge_hit = 1'b1;
      end
    end
  end

  assign miss_ready = (state_q == IDLE) && (merge_hit || (!pend_q && any_free));
  assign miss_acc   = miss_valid && miss_ready;
  // A merged miss rides on the read already in flight.
  assign alloc      = miss_acc && !merge_hit;

  // Datapath next-state
  always_comb begin
    busy_d       = busy_q;
    slot_addr_d  = slot_addr_q;
    iss_addr_d   = iss_addr_q;
    iss_xid_d    = iss_xid_q;
    pend_d       = pend_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    err_d        = err_q;

    if (pend_q && mem_ic_ready) begin
      pend_d = 1'b0;
    end

    if (mem_ic_valid) begin
      if (busy_q[mem_xxx_xid]) begin
        busy_d[mem_xxx_xid] = 1'b0;
        fill_valid_d        = 1'b1;
        fill_addr_d         = slot_addr_q[mem_xxx_xid];
        fill_data_d         = mem_xxx_data;
      end else begin
        err_d = 1'b1;
      end
    end

    // Allocation requires pend_q=0, so it never collides with the
    // acceptance clear above. The freed slot and the allocated slot are
    // always different: one is busy in busy_q, the other is free.
    if (alloc) begin
      busy_d[free_idx]      = 1'b1;
      slot_addr_d[free_idx] = miss_addr;
      iss_addr_d            = miss_addr;
      iss_xid_d             = free_idx;
      pend_d                = 1'b1;
    end
  end

  // Nothing outstanding once this cycle's updates land.
  assign drained = (busy_d == '0) && !pend_d;

  // Controller mode next-state. A flush with nothing outstanding completes
  // directly from IDLE so flush_done shows up the very next cycle.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          if (drained) begin
            flush_done_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      slot_addr_q  <= '{default: '0};
      iss_addr_q   <= '0;
      iss_xid_q    <= '0;
      pend_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      busy_q       <= busy_d;
      slot_addr_q  <= slot_addr_d;
      iss_addr_q   <= iss_addr_d;
      iss_xid_q    <= iss_xid_d;
      pend_q       <= pend_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      err_q        <= err_d;
      flush_done_q <= flush_done_d;
      state_q      <= state_d;
    end
  end

  assign ic_mem_re    = pend_q;
  assign ic_mem_addr  = iss_addr_q;
  assign ic_mem_xid   = iss_xid_q;
  assign fill_valid   = fill_valid_q;
  assign fill_addr    = fill_addr_q;
  assign fill_data    = fill_data_q;
  assign err_spurious = err_q;
  assign flush_done   = flush_done_q;
  // Popcount of the busy flops only, so it tracks the slot table with no
  // combinational input path.
  assign busy_cnt     = busy_count;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ic_fill_ctrl.sv
module tb_ic_fill_ctrl;
  import ic_pkg::*;

  logic        clk;
  logic        rst;
  logic        miss_valid;
  line_addr_t  miss_addr;
  logic        miss_ready;
  logic        flush;
  logic        flush_done;
  line_addr_t  ic_mem_addr;
  xid_t        ic_mem_xid;
  logic        ic_mem_re;
  logic        mem_ic_ready;
  logic        mem_ic_valid;
  xid_t        mem_xxx_xid;
  line_data_t  mem_xxx_data;
  logic        fill_valid;
  line_addr_t  fill_addr;
  line_data_t  fill_data;
  cnt_t        busy_cnt;
  logic        err_spurious;
  fill_state_e state_dbg;

  int total = 0;
  int bad   = 0;

  // Reference model: the set of outstanding lines, one record per XID in use.
  typedef struct {
    line_addr_t addr;
    xid_t       xid;
    bit         issued;
  } ent_t;

  ent_t        outq[$];
  bit          m_pend;
  bit          m_err;
  bit          m_drain;
  line_addr_t  m_iss_addr;
  xid_t        m_iss_xid;
  logic [150:0] exp_q[$];  // expected fills {addr, data}

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ic_fill_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .flush        (flush),
    .flush_done   (flush_done),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_xid   (ic_mem_xid),
    .ic_mem_re    (ic_mem_re),
    .mem_ic_ready (mem_ic_ready),
    .mem_ic_valid (mem_ic_valid),
    .mem_xxx_xid  (mem_xxx_xid),
    .mem_xxx_data (mem_xxx_data),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .busy_cnt     (busy_cnt),
    .err_spurious (err_spurious),
    .state_dbg    (state_dbg)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic line_data_t rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int lowest_free();
    for (int x = 0; x < N_XID; x++) begin
      bit used;
      used = 1'b0;
      foreach (outq[i]) if (outq[i].xid == xid_t'(x)) used = 1'b1;
      if (!used) return x;
    end
    return -1;
  endfunction

  function automatic int pick_issued(input bit random_pick);
    int cand[$];
    foreach (outq[i]) if (outq[i].issued) cand.push_back(i);
    if (cand.size() == 0) return -1;
    if (!random_pick) return cand[0];
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; flush = 1'b0; mem_ic_ready = 1'b0;
    mem_ic_valid = 1'b0; mem_xxx_xid = '0; mem_xxx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete(); exp_q.delete();
    m_pend = 1'b0; m_err = 1'b0; m_drain = 1'b0;
    chk("rst_ic_mem_re",    128'(ic_mem_re),    128'(0));
    chk("rst_fill_valid",   128'(fill_valid),   128'(0));
    chk("rst_flush_done",   128'(flush_done),   128'(0));
    chk("rst_err_spurious", 128'(err_spurious), 128'(0));
    chk("rst_busy_cnt",     128'(busy_cnt),     128'(0));
    chk("rst_ic_mem_addr",  128'(ic_mem_addr),  128'(0));
    chk("rst_ic_mem_xid",   128'(ic_mem_xid),   128'(0));
    chk("rst_state",        128'(state_dbg == DRAIN), 128'(0));
    #1;
    chk("rst_miss_ready",   128'(miss_ready),   128'(1));
  endtask

  // ---------------- driver + model: one clock cycle ----------------
  // Called shortly after a rising edge; returns shortly after the next one.
  task automatic step(input bit mv, input line_addr_t ma, input bit fl, input bit rdy,
                      input bit rv, input xid_t rx, input line_data_t rd, output bit acc);
    bit hit, exp_ready, exp_fill, exp_done, outstanding;
    int fx, idx;
    line_addr_t fa;
    logic [150:0] e;

    miss_valid = mv; miss_addr = ma; flush = fl; mem_ic_ready = rdy;
    mem_ic_valid = rv; mem_xxx_xid = rx; mem_xxx_data = rd;
    @(negedge clk);

    hit = 1'b0;
    foreach (outq[i]) if (outq[i].addr == ma) hit = 1'b1;
    fx = lowest_free();
    exp_ready = !m_drain && (hit || (!m_pend && fx >= 0));
    chk("miss_ready", 128'(miss_ready), 128'(exp_ready));
    acc = mv && exp_ready;

    if (m_pend && rdy) begin
      m_pend = 1'b0;
      foreach (outq[i]) if (outq[i].xid == m_iss_xid) outq[i].issued = 1'b1;
    end

    exp_fill = 1'b0;
    fa = '0;
    if (rv) begin
      idx = -1;
      foreach (outq[i]) if (outq[i].xid == rx) idx = i;
      if (idx >= 0) begin
        exp_fill = 1'b1;
        fa = outq[idx].addr;
        outq.delete(idx);
      end else begin
        m_err = 1'b1;
      end
    end

    if (acc && !hit) begin
      outq.push_back('{addr: ma, xid: xid_t'(fx), issued: 1'b0});
      m_pend = 1'b1;
      m_iss_addr = ma;
      m_iss_xid = xid_t'(fx);
    end

    exp_done = 1'b0;
    outstanding = (outq.size() != 0) || m_pend;
    if (m_drain) begin
      if (!outstanding) begin
        m_drain = 1'b0;
        exp_done = 1'b1;
      end
    end else if (fl) begin
      if (!outstanding) exp_done = 1'b1;
      else m_drain = 1'b1;
    end
    if (exp_fill) exp_q.push_back({fa, rd});

    @(posedge clk);
    #1;
    chk("ic_mem_re", 128'(ic_mem_re), 128'(m_pend));
    if (m_pend) begin
      chk("ic_mem_addr", 128'(ic_mem_addr), 128'(m_iss_addr));
      chk("ic_mem_xid",  128'(ic_mem_xid),  128'(m_iss_xid));
    end
    chk("fill_valid", 128'(fill_valid), 128'(exp_fill));
    if (exp_fill) begin
      e = exp_q.pop_front();
      chk("fill_addr", 128'(fill_addr), 128'(e[150:128]));
      chk("fill_data", fill_data, e[127:0]);
    end
    chk("busy_cnt",     128'(busy_cnt),     128'(outq.size()));
    chk("err_spurious", 128'(err_spurious), 128'(m_err));
    chk("flush_done",   128'(flush_done),   128'(exp_done));
    chk("state",        128'(state_dbg == DRAIN), 128'(m_drain));
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, a);
  endtask

  task automatic miss_accept(input line_addr_t ad, input bit rdy, input int max);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < max && !acc; k++) step(1'b1, ad, 1'b0, rdy, 1'b0, '0, '0, acc);
    if (!acc) begin
      total++; bad++;
      $error("FAIL miss_accept_timeout observed=0 expected=1 addr=%0h", ad);
    end
  endtask

  task automatic respond(input xid_t x, input line_data_t d);
    bit a;
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, x, d, a);
  endtask

  task automatic drain_all();
    bit a;
    int idx;
    int k;
    for (k = 0; k < 60; k++) begin
      if (outq.size() == 0 && !m_pend) break;
      idx = pick_issued(1'b0);
      if (idx >= 0) step(1'b0, '0, 1'b0, 1'b1, 1'b1, outq[idx].xid, rnd_line(), a);
      else step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, a);
    end
    if (k == 60) begin
      total++; bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", outq.size());
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit a;
    int idx;

    do_reset();

    // Single miss, response four cycles later.
    step(1'b1, 23'h000123, 1'b0, 1'b1, 1'b0, '0, '0, a);
    idle(3);
    respond(2'd0, {16{8'hA5}});
    idle(1);

    // Five distinct misses; the fifth waits until xid 2 returns.
    for (int i = 0; i < 4; i++) miss_accept(23'h000200 + 23'(i), 1'b1, 8);
    repeat (3) step(1'b1, 23'h000204, 1'b0, 1'b1, 1'b0, '0, '0, a);
    step(1'b1, 23'h000204, 1'b0, 1'b1, 1'b1, 2'd2, rnd_line(), a);
    miss_accept(23'h000204, 1'b1, 4);
    drain_all();

    // Duplicate miss merges into the in-flight read.
    miss_accept(23'h000040, 1'b1, 4);
    idle(1);
    miss_accept(23'h000040, 1'b1, 2);
    idle(1);
    respond(2'd0, rnd_line());
    idle(2);

    // Arbiter back-pressure for six cycles with a new miss waiting.
    miss_accept(23'h000777, 1'b0, 2);
    repeat (6) step(1'b1, 23'h000778, 1'b0, 1'b0, 1'b0, '0, '0, a);
    miss_accept(23'h000778, 1'b1, 4);
    drain_all();

    // Flush with two reads outstanding; a second flush mid-drain is ignored.
    miss_accept(23'h000500, 1'b1, 4);
    miss_accept(23'h000501, 1'b1, 4);
    idle(1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0, a);
    step(1'b1, 23'h000502, 1'b1, 1'b1, 1'b0, '0, '0, a);
    step(1'b1, 23'h000500, 1'b0, 1'b1, 1'b1, 2'd0, rnd_line(), a);
    step(1'b1, 23'h000502, 1'b0, 1'b1, 1'b0, '0, '0, a);
    step(1'b1, 23'h000502, 1'b0, 1'b1, 1'b1, 2'd1, rnd_line(), a);
    idle(2);

    // Flush with nothing outstanding.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, '0, a);
    idle(2);

    // Randomized traffic with a small address pool to provoke merges.
    for (int c = 0; c < 400; c++) begin
      bit rv;
      xid_t rx;
      rv = 1'b0;
      rx = '0;
      idx = pick_issued(1'b1);
      if (idx >= 0 && $urandom_range(0, 2) == 0) begin
        rv = 1'b1;
        rx = outq[idx].xid;
      end
      step(1'($urandom_range(0, 1)), 23'h000300 + 23'($urandom_range(0, 5)),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
           rv, rx, rnd_line(), a);
    end
    drain_all();
    idle(2);

    // Response to an idle XID: no fill, sticky error until reset.
    respond(2'd3, rnd_line());
    idle(3);
    do_reset();
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
